// File: rtl/inv_key_generator.sv
// AES-128 decryption key source: expands the cipher key forward to round 10,
// then walks the schedule backward, streaming k10..k0 over valid/ready.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        x2   = gf_mul(din, din);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        dout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
endmodule

module g_function (
    input  logic [31:0] w,
    input  logic [3:0]  rnd,
    output logic [31:0] g
);
    logic [31:0] rot;
    logic [31:0] sub;
    logic [7:0]  rcon;

    assign rot = {w[23:0], w[31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (.din(rot[8*i +: 8]), .dout(sub[8*i +: 8]));
        end
    endgenerate

    always_comb begin
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign g = sub ^ {rcon, 24'h000000};
endmodule

module inv_key_generator #(
    parameter int BLOCK_LENGTH = 128,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic [BLOCK_LENGTH-1:0] key,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [BLOCK_LENGTH-1:0] rk,
    output logic [3:0]              rk_index,
    output logic                    rk_last,
    output logic                    busy
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [BLOCK_LENGTH-1:0] cur_q, cur_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rk_valid_q, rk_last_q, busy_q;

    logic [31:0] wa, wb, wc, wd, d_back, g_in, g_out;
    logic [31:0] fa, fb, fc, fd;
    logic [BLOCK_LENGTH-1:0] fwd, bwd;

    assign wa = cur_q[127:96];
    assign wb = cur_q[95:64];
    assign wc = cur_q[63:32];
    assign wd = cur_q[31:0];

    // One g instance serves both directions; backward needs the recovered d'.
    assign d_back = wd ^ wc;
    assign g_in   = (state_q == EMIT) ? d_back : wd;

    g_function u_g (.w(g_in), .rnd(cnt_q), .g(g_out));

    assign fa  = wa ^ g_out;
    assign fb  = wb ^ fa;
    assign fc  = wc ^ fb;
    assign fd  = wd ^ fc;
    assign fwd = {fa, fb, fc, fd};
    assign bwd = {wa ^ g_out, wb ^ wa, wc ^ wb, d_back};

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    cur_d   = key;
                    cnt_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                cur_d = fwd;
                if (cnt_q == LAST_RND) state_d = EMIT;
                else                   cnt_d = cnt_q + 4'd1;
            end
            EMIT: begin
                if (rk_ready) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cur_d = bwd;
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            rk_valid_q <= (state_d == EMIT);
            rk_last_q  <= (state_d == EMIT) && (cnt_d == 4'd0);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign key_ready = (state_q == IDLE) && !rst;
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign busy      = busy_q;
    assign rk        = cur_q;
    assign rk_index  = cnt_q;
endmodule

// File: tb/tb_inv_key_generator.sv
// Directed bench for inv_key_generator: FIPS-197 schedules, backpressure,
// held key_valid, mid-job reset and back-to-back busy timing.
module tb_inv_key_generator;
    logic         clk = 1'b0;
    logic         rst, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
    logic [127:0] key, rk;
    logic [3:0]   rk_index;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_rk [0:10];
    bit           known  [0:10];

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    inv_key_generator #(.BLOCK_LENGTH(128), .NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_index(rk_index),
        .rk_last(rk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input logic [127:0] k);
        for (int i = 0; i <= 10; i++) begin
            exp_rk[i] = '0;
            known[i]  = 1'b0;
        end
        exp_rk[0] = k;
        known[0]  = 1'b1;
        if (k == K_FIPS) begin
            exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
            exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
            exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
            exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
            exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
            exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
            exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            for (int i = 1; i <= 10; i++) known[i] = 1'b1;
        end else begin
            exp_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            exp_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
            known[1]   = 1'b1;
            known[10]  = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic accept_key(input logic [127:0] k, input string tag, input bit hold,
                              input logic [127:0] hold_key);
        int n;
        key       = k;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept_wait"}, 128'(n < 100), 128'd1);
        @(negedge clk);
        if (hold) key = hold_key;
        else      key_valid = 1'b0;
    endtask

    task automatic wait_first(input string tag);
        int lat;
        chk({tag, " busy_start"}, 128'(busy), 128'd1);
        chk({tag, " ready_low"}, 128'(key_ready), 128'd0);
        lat = 0;
        while (!rk_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'd10);
        chk({tag, " ready_low_emit"}, 128'(key_ready), 128'd0);
    endtask

    task automatic collect(input bit bp, input string tag);
        int beats, cyc, stall;
        bit stalled;
        logic [127:0] hold_rk;
        logic [3:0]   hold_idx;
        beats = 0; cyc = 0; stall = 0; stalled = 1'b0;
        hold_rk = '0; hold_idx = '0;
        while (beats < 11 && cyc < 200) begin
            if (stalled) begin
                chk({tag, " stall_valid"}, 128'(rk_valid), 128'd1);
                chk({tag, " stall_rk"}, rk, hold_rk);
                chk({tag, " stall_idx"}, 128'(rk_index), 128'(hold_idx));
            end
            if (bp && stall < 5) rk_ready = 1'($urandom_range(0, 1));
            else                 rk_ready = 1'b1;
            if (rk_ready) stall = 0;
            else          stall++;
            if (rk_valid && rk_ready) begin
                chk({tag, " index"}, 128'(rk_index), 128'(10 - beats));
                if (known[10 - beats]) chk({tag, " rk"}, rk, exp_rk[10 - beats]);
                chk({tag, " last"}, 128'(rk_last), 128'(beats == 10));
                beats++;
            end
            stalled  = rk_valid && !rk_ready;
            hold_rk  = rk;
            hold_idx = rk_index;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " beats"}, 128'(beats), 128'd11);
        chk({tag, " valid_drop"}, 128'(rk_valid), 128'd0);
        chk({tag, " busy_end"}, 128'(busy), 128'd0);
        chk({tag, " ready_back"}, 128'(key_ready), 128'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " rk"}, rk, 128'd0);
        chk({tag, " idx"}, 128'(rk_index), 128'd0);
        chk({tag, " valid"}, 128'(rk_valid), 128'd0);
        chk({tag, " last"}, 128'(rk_last), 128'd0);
        chk({tag, " busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int seen, f, run1, gap, run2, k;
        bit bz [0:69];
        rst = 1'b1; key_valid = 1'b0; rk_ready = 1'b0; key = '0;

        // Reset state; key_ready must stay low while rst is high.
        @(negedge clk);
        chk_reset_outs("reset");
        chk("reset key_ready", 128'(key_ready), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset key_ready", 128'(key_ready), 128'd1);

        // Basic FIPS-197 key, ready tied high.
        load_exp(K_FIPS);
        accept_key(K_FIPS, "basic", 1'b0, '0);
        wait_first("basic");
        collect(1'b0, "basic");

        // Second reference key.
        load_exp(K_SEQ);
        accept_key(K_SEQ, "seq", 1'b0, '0);
        wait_first("seq");
        collect(1'b0, "seq");

        // Random backpressure.
        load_exp(K_FIPS);
        accept_key(K_FIPS, "bp", 1'b0, '0);
        wait_first("bp");
        collect(1'b1, "bp");

        // key_valid held with a different key through a whole job.
        rk_ready = 1'b1;
        load_exp(K_FIPS);
        accept_key(K_FIPS, "hold", 1'b1, K_SEQ);
        wait_first("hold");
        collect(1'b0, "hold");
        load_exp(K_SEQ);
        @(negedge clk);
        key_valid = 1'b0;
        wait_first("hold2");
        collect(1'b0, "hold2");

        // Reset during EXPAND while cnt is 5.
        accept_key(K_FIPS, "rstx", 1'b0, '0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("rst_expand");
        @(negedge clk);
        chk("rst_expand key_ready", 128'(key_ready), 128'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rk_valid) seen++;
        end
        chk("rst_expand no_emit", 128'(seen), 128'd0);

        // Reset during EMIT at index 6.
        accept_key(K_FIPS, "rste", 1'b0, '0);
        wait_first("rste");
        rk_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_emit at_idx6", 128'(rk_index), 128'd6);
        rk_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("rst_emit");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rk_valid) seen++;
        end
        chk("rst_emit no_emit", 128'(seen), 128'd0);

        // A job after reset runs normally.
        load_exp(K_SEQ);
        accept_key(K_SEQ, "after_rst", 1'b0, '0);
        wait_first("after_rst");
        collect(1'b0, "after_rst");

        // Back-to-back jobs: 21 busy cycles, one idle cycle between.
        rk_ready = 1'b1;
        key = K_FIPS;
        key_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            bz[i] = busy;
        end
        key_valid = 1'b0;
        f = 0;
        while (f < 70 && !bz[f]) f++;
        k = f; run1 = 0;
        while (k < 70 && bz[k])  begin run1++; k++; end
        gap = 0;
        while (k < 70 && !bz[k]) begin gap++;  k++; end
        run2 = 0;
        while (k < 70 && bz[k])  begin run2++; k++; end
        chk("b2b first_accept", 128'(f), 128'd0);
        chk("b2b busy_run1", 128'(run1), 128'd21);
        chk("b2b idle_gap", 128'(gap), 128'd1);
        chk("b2b busy_run2", 128'(run2), 128'd21);
        k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("b2b drain", 128'(busy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
